wav_stream_packer: RTL and testbench
====================================

WAV_STREAM_PACKER -- requirements
Module: wav_stream_packer

Interface
REQ-001 Parameter NUM_CHANNELS, default 2: channels per frame, legal 1..8.
REQ-002 Parameter BITS_PER_SAMPLE, default 24: sample width, legal 8/16/24/32.
REQ-003 Parameter CLK_DIV, default 1088: clk_i cycles per sample tick; legal >= NUM_CHANNELS*BITS_PER_SAMPLE/8 + 2.
REQ-004 clk_i  in  1  single clock, all logic on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 en_i  in  1  run enable for the sample-rate divider.
REQ-007 clr_i  in  1  synchronous pulse; clears overrun_o and byte_count_o.
REQ-008 samples_i  in  NUM_CHANNELS*BITS_PER_SAMPLE  signed samples; channel 0 in the LSBs.
REQ-009 byte_o  out  8  current output byte.
REQ-010 valid_o  out  1  byte_o valid.
REQ-011 ready_i  in  1  downstream accepts byte_o when valid_o and ready_i are both high.
REQ-012 tick_o  out  1  one-cycle sample-rate strobe.
REQ-013 busy_o  out  1  high while a frame is being serialized.
REQ-014 overrun_o  out  1  sticky; a tick arrived while a frame was still pending.
REQ-015 byte_count_o  out  32  accepted data bytes since reset or clear.

Function
REQ-016 The divider counter shall count 0..CLK_DIV-1 while en_i=1 and be held at 0 while en_i=0.
REQ-017 tick_o shall be high for exactly the cycle in which the counter equals CLK_DIV-1 and en_i=1; the first tick comes CLK_DIV cycles after en_i is first sampled high.
REQ-018 The FSM states shall be IDLE, WAIT_TICK and SEND.
REQ-019 IDLE->WAIT_TICK when en_i=1; WAIT_TICK->IDLE when en_i=0.
REQ-020 In WAIT_TICK, a tick shall latch samples_i into the frame register, set byte index 0, and go to SEND; valid_o rises the next cycle (latency 1).
REQ-021 In SEND, valid_o=1 and busy_o=1. byte_o shall be frame byte[index]: channel 0 first, each sample least-significant byte first (little-endian, WAV order).
REQ-022 byte_o and valid_o shall hold steady while valid_o=1 and ready_i=0.
REQ-023 Each handshake shall increment the index and byte_count_o; byte_count_o wraps modulo 2^32.
REQ-024 On the handshake of the last byte (index NUM_CHANNELS*BITS_PER_SAMPLE/8-1): if tick_o=1 in that cycle, latch a new frame and stay in SEND at index 0 with no overrun; else go to WAIT_TICK if en_i=1, or to IDLE if en_i=0.
REQ-025 A tick in SEND that does not coincide with the last-byte handshake shall set overrun_o; that sample is dropped and the current frame continues unaltered.
REQ-026 Deasserting en_i during SEND shall not abort the frame; it completes, then the FSM goes to IDLE.
REQ-027 When BITS_PER_SAMPLE=8, each sample's MSB shall be inverted at latch time (signed to WAV unsigned-offset); widths >8 shall pass unmodified.
REQ-028 clr_i shall zero byte_count_o and overrun_o next cycle; clr_i wins over a simultaneous increment or overrun event (the result is 0).

Reset
REQ-029 While rst_i=1: state IDLE, divider 0, index 0, frame register 0, byte_o=0, valid_o=0, tick_o=0, busy_o=0, overrun_o=0, byte_count_o=0.
REQ-030 Reset mid-frame shall discard the frame with no further valid_o until a new tick after release.

Verification (NUM_CHANNELS=2, BITS_PER_SAMPLE=24, CLK_DIV=16 unless noted)
REQ-031 en_i=1, ready_i=1, L=0x123456, R=0xABCDEF -> bytes 56,34,12,EF,CD,AB on 6 consecutive cycles starting 1 cycle after tick; byte_count_o=6.
REQ-032 Same frame, ready_i toggled 1,0,0,1... -> identical byte sequence, bytes held during stalls, no overrun; after 3 frames byte_count_o=18.
REQ-033 ready_i=0 for 20 cycles after the first tick -> second tick sets overrun_o=1, frame 1 still delivered intact once ready_i=1; clr_i -> overrun_o=0, byte_count_o=0.
REQ-034 BITS_PER_SAMPLE=8, NUM_CHANNELS=1, CLK_DIV=4, samples 0x80, 0x7F, 0x00 -> bytes 0x00, 0xFF, 0x80.
REQ-035 rst_i asserted after byte 3 of a frame -> all outputs 0 immediately; after release with en_i=1, the next frame starts at byte 0 after CLK_DIV cycles.
REQ-036 en_i dropped mid-frame -> remaining bytes delivered, then busy_o=0, no further tick_o.

Source files
------------

// File: rtl/wav_stream_packer.sv
// Serializes multichannel PCM frames into a little-endian WAV byte stream.
// An internal divider paces the frames and a ready/valid handshake carries the bytes.
module wav_stream_packer #(
    parameter int unsigned NUM_CHANNELS    = 2,
    parameter int unsigned BITS_PER_SAMPLE = 24,
    parameter int unsigned CLK_DIV         = 1088
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    en_i,
    input  logic                                    clr_i,
    input  logic [NUM_CHANNELS*BITS_PER_SAMPLE-1:0] samples_i,
    output logic [7:0]                              byte_o,
    output logic                                    valid_o,
    input  logic                                    ready_i,
    output logic                                    tick_o,
    output logic                                    busy_o,
    output logic                                    overrun_o,
    output logic [31:0]                             byte_count_o
);

    localparam int unsigned FrameW   = NUM_CHANNELS * BITS_PER_SAMPLE;
    localparam int unsigned NumBytes = FrameW / 8;
    localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam int unsigned CntW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitTick,
        StSend
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [FrameW-1:0]  frame_q, frame_d;
    logic               overrun_q, overrun_d;
    logic [31:0]        count_q, count_d;

    logic               tick;
    logic               handshake;
    logic               last_byte;
    logic               last_hs;
    logic               load_frame;
    logic [FrameW-1:0]  frame_in;

    // 8-bit WAV samples are unsigned-offset, so flip each sample's sign bit.
    generate
        if (BITS_PER_SAMPLE == 8) begin : g_offset
            for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
                assign frame_in[c*8 +: 8] = {~samples_i[c*8+7], samples_i[c*8 +: 7]};
            end
        end else begin : g_pass
            assign frame_in = samples_i;
        end
    endgenerate

    assign tick      = en_i && (cnt_q == CntMax);
    assign handshake = (state_q == StSend) && ready_i;
    assign last_byte = (idx_q == LastIdx);
    assign last_hs   = handshake && last_byte;
    assign load_frame = tick && ((state_q == StWaitTick) || last_hs);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (en_i) state_d = StWaitTick;
            end
            StWaitTick: begin
                if (tick) begin
                    state_d = StSend;
                end else if (!en_i) begin
                    state_d = StIdle;
                end
            end
            StSend: begin
                // A frame always completes; en_i only decides where to go after it.
                if (last_hs) begin
                    if (tick) begin
                        state_d = StSend;
                    end else if (en_i) begin
                        state_d = StWaitTick;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        frame_d   = frame_q;
        idx_d     = idx_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (load_frame) begin
            frame_d = frame_in;
            idx_d   = '0;
        end else if (last_hs) begin
            idx_d = '0;
        end else if (handshake) begin
            idx_d = idx_q + 1'b1;
        end
        if (handshake) begin
            count_d = count_q + 32'd1;
        end
        if ((state_q == StSend) && tick && !last_hs) begin
            overrun_d = 1'b1;
        end
        if (clr_i) begin
            count_d   = '0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    // Output logic
    always_comb begin
        byte_o  = 8'h00;
        valid_o = 1'b0;
        busy_o  = 1'b0;
        if (state_q == StSend) begin
            valid_o = 1'b1;
            busy_o  = 1'b1;
            for (int i = 0; i < NumBytes; i++) begin
                if (idx_q == IdxW'(i)) byte_o = frame_q[i*8 +: 8];
            end
        end
    end

    assign tick_o       = tick;
    assign overrun_o    = overrun_q;
    assign byte_count_o = count_q;

endmodule

// File: tb/tb_wav_stream_packer.sv
// Bench for wav_stream_packer: directed and random steps checked against a
// queue-based model of ticks, frame bytes, byte count and overrun.
module tb_wav_stream_packer;

    localparam int unsigned NC  = 2;
    localparam int unsigned BPS = 24;
    localparam int unsigned DIV = 16;
    localparam int unsigned NB  = NC * BPS / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, en, clr, ready;
    logic [NC*BPS-1:0] samples;
    logic [7:0]        byte_a;
    logic              valid_a, tick_a, busy_a, ovr_a;
    logic [31:0]       cnt_a;

    logic              en_b, clr_b, ready_b;
    logic [7:0]        samp_b;
    logic [7:0]        byte_b;
    logic              valid_b, tick_b, busy_b, ovr_b;
    logic [31:0]       cnt_b;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  exp_q[$];
    int          en_run;
    logic [31:0] m_count;
    logic        m_ovr;

    logic [7:0] exp31[6] = '{8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB};
    logic [7:0] vb[3]    = '{8'h80, 8'h7F, 8'h00};
    logic [7:0] eb[3]    = '{8'h00, 8'hFF, 8'h80};

    wav_stream_packer #(
        .NUM_CHANNELS   (NC),
        .BITS_PER_SAMPLE(BPS),
        .CLK_DIV        (DIV)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .clr_i       (clr),
        .samples_i   (samples),
        .byte_o      (byte_a),
        .valid_o     (valid_a),
        .ready_i     (ready),
        .tick_o      (tick_a),
        .busy_o      (busy_a),
        .overrun_o   (ovr_a),
        .byte_count_o(cnt_a)
    );

    wav_stream_packer #(
        .NUM_CHANNELS   (1),
        .BITS_PER_SAMPLE(8),
        .CLK_DIV        (4)
    ) u_dut8 (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en_b),
        .clr_i       (clr_b),
        .samples_i   (samp_b),
        .byte_o      (byte_b),
        .valid_o     (valid_b),
        .ready_i     (ready_b),
        .tick_o      (tick_b),
        .busy_o      (busy_b),
        .overrun_o   (ovr_b),
        .byte_count_o(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [NC*BPS-1:0] s);
        logic [NC*BPS-1:0] t;
        logic [7:0]        v;
        for (int c = 0; c < NC; c++) begin
            for (int b = 0; b < BPS / 8; b++) begin
                t = s >> (c * BPS + 8 * b);
                v = t[7:0];
                if (BPS == 8) v = v ^ 8'h80;
                exp_q.push_back(v);
            end
        end
    endtask

    // Check outputs for the current cycle, advance the model across the next edge.
    task automatic cycle();
        logic tick_e, hs, pend;
        #1;
        if (rst) begin
            exp_q.delete();
            en_run  = 0;
            m_count = 0;
            m_ovr   = 1'b0;
            check("rst_tick", {31'd0, tick_a}, 0);
            check("rst_valid", {31'd0, valid_a}, 0);
            check("rst_busy", {31'd0, busy_a}, 0);
            check("rst_byte", {24'd0, byte_a}, 0);
            check("rst_count", cnt_a, 0);
            check("rst_overrun", {31'd0, ovr_a}, 0);
        end else begin
            tick_e = en && (((en_run + 1) % DIV) == 0);
            pend   = (exp_q.size() != 0);
            check("tick", {31'd0, tick_a}, {31'd0, tick_e});
            check("valid", {31'd0, valid_a}, {31'd0, pend});
            check("busy", {31'd0, busy_a}, {31'd0, pend});
            check("byte", {24'd0, byte_a}, pend ? {24'd0, exp_q[0]} : 32'd0);
            check("count", cnt_a, m_count);
            check("overrun", {31'd0, ovr_a}, {31'd0, m_ovr});
            hs = pend && ready;
            if (hs) begin
                void'(exp_q.pop_front());
                m_count = m_count + 1;
            end
            if (tick_e) begin
                if (exp_q.size() == 0) push_frame(samples);
                else m_ovr = 1'b1;
            end
            if (clr) begin
                m_count = 0;
                m_ovr   = 1'b0;
            end
            en_run = en ? en_run + 1 : 0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] r64;
        rst = 1'b1; en = 1'b0; clr = 1'b0; ready = 1'b0; samples = '0;
        en_b = 1'b0; clr_b = 1'b0; ready_b = 1'b0; samp_b = 8'h00;
        en_run = 0; m_count = 0; m_ovr = 1'b0;
        @(negedge clk);
        repeat (3) cycle();
        rst = 1'b0;

        // Basic frame, ready always high
        samples = {24'hABCDEF, 24'h123456};
        en = 1'b1; ready = 1'b1;
        repeat (DIV) cycle();
        for (int i = 0; i < 6; i++) begin
            #1 check("req31_byte", {24'd0, byte_a}, {24'd0, exp31[i]});
            cycle();
        end
        #1 check("req31_count", cnt_a, 32'd6);

        // Stalled handshakes over three frames
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 57; i++) begin
            ready = ((i % 4) == 0) || ((i % 4) == 3);
            cycle();
        end
        #1 check("req32_count", cnt_a, 32'd18);
        check("req32_overrun", {31'd0, ovr_a}, 0);

        // Long stall forces an overrun; pending frame must still come out intact
        ready = 1'b0;
        for (int i = 0; i < 36; i++) begin
            r64 = {$urandom, $urandom};
            samples = r64[NC*BPS-1:0];
            cycle();
        end
        #1 check("req33_overrun_set", {31'd0, ovr_a}, 1);
        ready = 1'b1;
        repeat (8) cycle();
        #1 check("req33_count", cnt_a, 32'd24);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        #1 check("req33_clr_overrun", {31'd0, ovr_a}, 0);
        check("req33_clr_count", cnt_a, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            ready = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 79) == 0);
            r64 = {$urandom, $urandom};
            samples = r64[NC*BPS-1:0];
            cycle();
        end
        clr = 1'b0;

        // Drop enable mid-frame
        en = 1'b1; ready = 1'b1;
        for (int i = 0; i < 3 * DIV && exp_q.size() == 0; i++) cycle();
        repeat (2) cycle();
        en = 1'b0;
        repeat (40) cycle();
        #1 check("req36_busy", {31'd0, busy_a}, 0);
        check("req36_valid", {31'd0, valid_a}, 0);

        // Reset mid-frame
        en = 1'b1;
        for (int i = 0; i < 3 * DIV && exp_q.size() == 0; i++) cycle();
        repeat (3) cycle();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (DIV + NB + 4) cycle();
        en = 1'b0;

        // 8-bit mono instance: sign-bit flip
        ready_b = 1'b1; en_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int w;
            samp_b = vb[k];
            w = 0;
            #1;
            while (!tick_b && w < 16) begin
                @(negedge clk);
                #1;
                w++;
            end
            check("b_tick_seen", {31'd0, tick_b}, 1);
            @(negedge clk);
            samp_b = ~vb[k];
            #1;
            check("b_valid", {31'd0, valid_b}, 1);
            check("b_byte", {24'd0, byte_b}, {24'd0, eb[k]});
            @(negedge clk);
        end
        #1 check("b_count", cnt_b, 32'd3);
        check("b_overrun", {31'd0, ovr_b}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
